// File: rtl/pc_select_reg.sv
// Program-counter update unit: selects the next PC from NUM_SRC flattened sources,
// commits it under write / conditional-write control, and traps on misaligned or out-of-range targets.
module pc_select_reg #(
  parameter int                DATA_W      = 32,
  parameter int                NUM_SRC     = 6,
  parameter int                SEL_W       = 3,
  parameter logic [DATA_W-1:0] RESET_PC    = '0,
  parameter logic [DATA_W-1:0] TRAP_PC     = DATA_W'(32'h0000_00FF),
  parameter bit                ALIGN_CHECK = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_SRC*DATA_W-1:0] src_flat,
  input  logic                      pc_write,
  input  logic                      pc_write_cond,
  input  logic                      cond,
  input  logic                      trap_ack,
  output logic [DATA_W-1:0]         pc,
  output logic [DATA_W-1:0]         epc,
  output logic [DATA_W-1:0]         next_pc,
  output logic                      in_trap,
  output logic                      fault_align,
  output logic                      fault_sel,
  output logic [15:0]               load_cnt
);

  typedef enum logic [0:0] {RUN = 1'b0, TRAP = 1'b1} state_t;

  localparam logic [SEL_W:0] NUM_SRC_W = (SEL_W+1)'(NUM_SRC);

  state_t              state_r, state_nxt;
  logic [DATA_W-1:0]   pc_r, pc_nxt;
  logic [DATA_W-1:0]   epc_r, epc_nxt;
  logic                fault_align_r, fault_align_nxt;
  logic                fault_sel_r, fault_sel_nxt;
  logic [15:0]         load_cnt_r, load_cnt_nxt;
  logic [DATA_W-1:0]   next_pc_s;
  logic                load_req_s;
  logic                sel_bad_s;
  logic                align_bad_s;

  // One-hot OR mux; an out-of-range selector matches nothing and yields zero.
  always_comb begin
    next_pc_s = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      next_pc_s = next_pc_s |
                  ({DATA_W{({1'b0, sel} == (SEL_W+1)'(k))}} & src_flat[k*DATA_W +: DATA_W]);
    end
  end

  assign load_req_s  = pc_write | (pc_write_cond & cond);
  assign sel_bad_s   = ({1'b0, sel} >= NUM_SRC_W);
  assign align_bad_s = ALIGN_CHECK && !sel_bad_s && (next_pc_s[1:0] != 2'b00);

  // Next-state and next-register values; selector fault outranks alignment fault.
  always_comb begin
    state_nxt       = state_r;
    pc_nxt          = pc_r;
    epc_nxt         = epc_r;
    fault_align_nxt = fault_align_r;
    fault_sel_nxt   = fault_sel_r;
    load_cnt_nxt    = load_cnt_r;
    case (state_r)
      RUN: begin
        if (load_req_s) begin
          if (sel_bad_s) begin
            epc_nxt         = pc_r;
            pc_nxt          = TRAP_PC;
            state_nxt       = TRAP;
            fault_sel_nxt   = 1'b1;
            fault_align_nxt = 1'b0;
          end else if (align_bad_s) begin
            epc_nxt         = pc_r;
            pc_nxt          = TRAP_PC;
            state_nxt       = TRAP;
            fault_sel_nxt   = 1'b0;
            fault_align_nxt = 1'b1;
          end else begin
            pc_nxt          = next_pc_s;
            load_cnt_nxt    = load_cnt_r + 16'd1;
            fault_sel_nxt   = 1'b0;
            fault_align_nxt = 1'b0;
          end
        end else begin
          state_nxt = RUN;
        end
      end
      TRAP: begin
        // Loads are dropped here, even in the acknowledge cycle.
        if (trap_ack) begin
          state_nxt = RUN;
        end else begin
          state_nxt = TRAP;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r          <= RESET_PC;
      epc_r         <= '0;
      fault_align_r <= 1'b0;
      fault_sel_r   <= 1'b0;
      load_cnt_r    <= 16'd0;
    end else begin
      pc_r          <= pc_nxt;
      epc_r         <= epc_nxt;
      fault_align_r <= fault_align_nxt;
      fault_sel_r   <= fault_sel_nxt;
      load_cnt_r    <= load_cnt_nxt;
    end
  end

  assign pc          = pc_r;
  assign epc         = epc_r;
  assign next_pc     = next_pc_s;
  assign in_trap     = (state_r == TRAP);
  assign fault_align = fault_align_r;
  assign fault_sel   = fault_sel_r;
  assign load_cnt    = load_cnt_r;

endmodule

// File: tb/tb_pc_select_reg.sv
// Scoreboard bench for pc_select_reg: a default 32-bit instance and a 16-bit,
// 4-source, no-alignment-check instance.
module tb_pc_select_reg;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: defaults
  logic [2:0]   sel_a = 3'd0;
  logic [191:0] src_a = {32'h0000_0300, 32'h0000_0200, 32'h0000_0102,
                         32'h0000_0080, 32'h0000_0040, 32'h0000_0004};
  logic pw_a = 1'b0, pwc_a = 1'b0, cond_a = 1'b0, ack_a = 1'b0;
  logic [31:0] pc_a, epc_a, next_pc_a;
  logic in_trap_a, fa_a, fs_a;
  logic [15:0] cnt_a;

  pc_select_reg dut_a (
    .clk(clk), .reset(reset), .sel(sel_a), .src_flat(src_a),
    .pc_write(pw_a), .pc_write_cond(pwc_a), .cond(cond_a), .trap_ack(ack_a),
    .pc(pc_a), .epc(epc_a), .next_pc(next_pc_a), .in_trap(in_trap_a),
    .fault_align(fa_a), .fault_sel(fs_a), .load_cnt(cnt_a)
  );

  // Instance B: narrow, four sources, no alignment check
  logic [1:0]  sel_b = 2'd0;
  logic [63:0] src_b = {16'h0003, 16'h0042, 16'h0021, 16'h0010};
  logic pw_b = 1'b0, pwc_b = 1'b0, cond_b = 1'b0, ack_b = 1'b0;
  logic [15:0] pc_b, epc_b, next_pc_b;
  logic in_trap_b, fa_b, fs_b;
  logic [15:0] cnt_b;

  pc_select_reg #(
    .DATA_W(16), .NUM_SRC(4), .SEL_W(2), .RESET_PC(16'h0000),
    .TRAP_PC(16'h00FF), .ALIGN_CHECK(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .sel(sel_b), .src_flat(src_b),
    .pc_write(pw_b), .pc_write_cond(pwc_b), .cond(cond_b), .trap_ack(ack_b),
    .pc(pc_b), .epc(epc_b), .next_pc(next_pc_b), .in_trap(in_trap_b),
    .fault_align(fa_b), .fault_sel(fs_b), .load_cnt(cnt_b)
  );

  typedef struct {
    int          cyc;
    bit          dut;   // 0 = A, 1 = B
    bit          kind;  // 0 = next_pc only, 1 = registered state
    logic [31:0] nxt;
    logic [31:0] pc;
    logic [31:0] epc;
    bit          trap;
    bit          fa;
    bit          fs;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  event sb_kick;
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic cmp(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, c, act, exp);
    end
  endtask

  // Monitor: pops every expectation that has come due and compares it.
  initial begin : monitor
    exp_t e;
    logic [31:0] a_nxt, a_pc, a_epc;
    logic a_t, a_fa, a_fs;
    logic [15:0] a_cnt;
    forever begin
      @(negedge clk or sb_kick);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        if (e.dut == 1'b0) begin
          a_nxt = next_pc_a; a_pc = pc_a; a_epc = epc_a;
          a_t = in_trap_a; a_fa = fa_a; a_fs = fs_a; a_cnt = cnt_a;
        end else begin
          a_nxt = {16'h0, next_pc_b}; a_pc = {16'h0, pc_b}; a_epc = {16'h0, epc_b};
          a_t = in_trap_b; a_fa = fa_b; a_fs = fs_b; a_cnt = cnt_b;
        end
        if (e.kind == 1'b0) begin
          cmp(e.dut ? "b.next_pc" : "a.next_pc", e.cyc, a_nxt, e.nxt);
        end else begin
          cmp(e.dut ? "b.pc" : "a.pc", e.cyc, a_pc, e.pc);
          cmp(e.dut ? "b.epc" : "a.epc", e.cyc, a_epc, e.epc);
          cmp(e.dut ? "b.in_trap" : "a.in_trap", e.cyc, {31'h0, a_t}, {31'h0, e.trap});
          cmp(e.dut ? "b.fault_align" : "a.fault_align", e.cyc, {31'h0, a_fa}, {31'h0, e.fa});
          cmp(e.dut ? "b.fault_sel" : "a.fault_sel", e.cyc, {31'h0, a_fs}, {31'h0, e.fs});
          cmp(e.dut ? "b.load_cnt" : "a.load_cnt", e.cyc, {16'h0, a_cnt}, {16'h0, e.cnt});
        end
      end
    end
  end

  // Drive one cycle of stimulus on one instance; push next_pc (now) and state (after the edge).
  task automatic step(input bit dut, input logic [2:0] sel, input bit pw, input bit pwc,
                      input bit cnd, input bit ack, input logic [31:0] e_nxt,
                      input logic [31:0] e_pc, input logic [31:0] e_epc, input bit e_t,
                      input bit e_fa, input bit e_fs, input logic [15:0] e_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    if (dut == 1'b0) begin
      sel_a = sel; pw_a = pw; pwc_a = pwc; cond_a = cnd; ack_a = ack;
      pw_b = 1'b0; pwc_b = 1'b0; cond_b = 1'b0; ack_b = 1'b0;
    end else begin
      sel_b = sel[1:0]; pw_b = pw; pwc_b = pwc; cond_b = cnd; ack_b = ack;
      pw_a = 1'b0; pwc_a = 1'b0; cond_a = 1'b0; ack_a = 1'b0;
    end
    e = '{cyc: cyc, dut: dut, kind: 1'b0, nxt: e_nxt, pc: 32'h0, epc: 32'h0,
          trap: 1'b0, fa: 1'b0, fs: 1'b0, cnt: 16'h0};
    sb_q.push_back(e);
    e = '{cyc: cyc + 1, dut: dut, kind: 1'b1, nxt: 32'h0, pc: e_pc, epc: e_epc,
          trap: e_t, fa: e_fa, fs: e_fs, cnt: e_cnt};
    sb_q.push_back(e);
  endtask

  // Mid-cycle reset pulse; both instances must clear before any clock edge.
  task automatic reset_pulse();
    exp_t e;
    @(posedge clk);
    #1;
    pw_a = 1'b0; pwc_a = 1'b0; cond_a = 1'b0; ack_a = 1'b0;
    pw_b = 1'b0; pwc_b = 1'b0; cond_b = 1'b0; ack_b = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      e = '{cyc: cyc, dut: d[0], kind: 1'b1, nxt: 32'h0, pc: 32'h0, epc: 32'h0,
            trap: 1'b0, fa: 1'b0, fs: 1'b0, cnt: 16'h0};
      sb_q.push_back(e);
    end
    ->sb_kick;
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: bench did not finish, pending=%0d", sb_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;

    reset_pulse();
    for (int i = 0; i < 10; i++)
      step(0, 3'd0, 0, 0, 0, 0, 32'h4, 32'h0, 32'h0, 0, 0, 0, 16'd0);

    // normal select, conditional write with cond low then high
    step(0, 3'd1, 1, 0, 0, 0, 32'h40,  32'h40,  32'h0, 0, 0, 0, 16'd1);
    step(0, 3'd2, 0, 1, 0, 0, 32'h80,  32'h40,  32'h0, 0, 0, 0, 16'd1);
    step(0, 3'd2, 0, 1, 1, 0, 32'h80,  32'h80,  32'h0, 0, 0, 0, 16'd2);
    // misaligned target traps; loads ignored while trapped and on the ack cycle
    step(0, 3'd3, 1, 0, 0, 0, 32'h102, 32'hFF,  32'h80, 1, 1, 0, 16'd2);
    for (int i = 0; i < 3; i++)
      step(0, 3'd1, 1, 0, 0, 0, 32'h40, 32'hFF, 32'h80, 1, 1, 0, 16'd2);
    step(0, 3'd0, 1, 0, 0, 1, 32'h4,   32'hFF,  32'h80, 0, 1, 0, 16'd2);
    // both write requests at once count as one load and clear the flag
    step(0, 3'd0, 1, 1, 1, 0, 32'h4,   32'h4,   32'h80, 0, 0, 0, 16'd3);
    step(0, 3'd0, 0, 0, 0, 1, 32'h4,   32'h4,   32'h80, 0, 0, 0, 16'd3);
    // out-of-range selector
    step(0, 3'd7, 1, 0, 0, 0, 32'h0,   32'hFF,  32'h4,  1, 0, 1, 16'd3);
    step(0, 3'd6, 0, 0, 0, 1, 32'h0,   32'hFF,  32'h4,  0, 0, 1, 16'd3);
    step(0, 3'd5, 1, 0, 0, 0, 32'h300, 32'h300, 32'h4,  0, 0, 0, 16'd4);
    // reset while trapped needs no ack
    step(0, 3'd3, 1, 0, 0, 0, 32'h102, 32'hFF,  32'h300, 1, 1, 0, 16'd4);
    reset_pulse();
    step(0, 3'd0, 0, 0, 0, 0, 32'h4,   32'h0,   32'h0,  0, 0, 0, 16'd0);

    // 65536 loads wrap the counter back to zero
    for (int i = 0; i < 65536; i++) begin
      if (i % 2 == 0)
        step(0, 3'd4, 1, 0, 0, 0, 32'h200, 32'h200, 32'h0, 0, 0, 0, 16'(i + 1));
      else
        step(0, 3'd5, 1, 0, 0, 0, 32'h300, 32'h300, 32'h0, 0, 0, 0, 16'(i + 1));
    end

    // narrow instance: odd targets load, sel=3 is valid
    step(1, 3'd3, 1, 0, 0, 0, 32'h3,  32'h3,  32'h0, 0, 0, 0, 16'd1);
    step(1, 3'd1, 0, 1, 1, 0, 32'h21, 32'h21, 32'h0, 0, 0, 0, 16'd2);
    step(1, 3'd2, 0, 0, 0, 0, 32'h42, 32'h21, 32'h0, 0, 0, 0, 16'd2);

    repeat (3) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pc_select_reg.md
Name: pc_select_reg

Overview:
Parametrised program-counter update unit for the multicycle datapath. It selects the next PC from NUM_SRC flattened sources, registers it under write / conditional-write control, and checks word alignment and selector range. It traps faults to a fixed vector with EPC capture and holds in TRAP until the control unit acknowledges. It replaces the bare next-PC mux plus external PC register, and sits between the control unit, ALU/ALUOut, EPC path and the instruction-memory address port.

Parameters:
DATA_W, 32, width of PC and each source
NUM_SRC, 6, number of selectable sources (2..2**SEL_W)
SEL_W, 3, selector width
RESET_PC, 32'h0000_0000, PC value on reset
TRAP_PC, 32'h0000_00FF, PC loaded on any fault
ALIGN_CHECK, 1, 1 = fault on misaligned target (low 2 bits nonzero); 0 = no check

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
sel  in  SEL_W  source index; source k occupies src_flat[k*DATA_W +: DATA_W]
src_flat  in  NUM_SRC*DATA_W  concatenated candidate PCs
pc_write  in  1  unconditional load request
pc_write_cond  in  1  conditional load request (branch)
cond  in  1  branch condition, qualifies pc_write_cond
trap_ack  in  1  control unit acknowledges trap, returns to RUN
pc  out  DATA_W  current PC (registered)
epc  out  DATA_W  PC at time of last fault (registered)
next_pc  out  DATA_W  combinational selected source (0 when sel out of range)
in_trap  out  1  1 while in TRAP state
fault_align  out  1  sticky: last fault was misalignment
fault_sel  out  1  sticky: last fault was out-of-range sel
load_cnt  out  16  count of committed PC loads, wraps

Behaviour:
- Reset (async, any time, including mid-trap): pc=RESET_PC, epc=0, state=RUN, in_trap=0, fault_align=0, fault_sel=0, load_cnt=0. Takes effect immediately, not at the next edge.
- load_req = pc_write | (pc_write_cond & cond).
- sel_bad = (sel >= NUM_SRC); align_bad = ALIGN_CHECK & (next_pc[1:0] != 0).
- States: RUN, TRAP. in_trap = (state==TRAP).
- RUN, load_req=0: all registers hold.
- RUN, load_req=1, sel_bad=0, align_bad=0: pc <= next_pc on the same edge (1-cycle latency); load_cnt += 1, wrapping 16'hFFFF -> 0.
- RUN, load_req=1, sel_bad=1: fault.
  - epc <= pc (the current PC, not the target); pc <= TRAP_PC; state <= TRAP.
  - fault_sel <= 1, fault_align <= 0; load_cnt unchanged.
- RUN, load_req=1, sel_bad=0, align_bad=1: same as the sel fault, but fault_align <= 1, fault_sel <= 0.
- sel_bad takes priority over align_bad; next_pc=0 when sel_bad, so no alignment check applies.
- TRAP: all load requests ignored and pc holds at TRAP_PC. epc and fault flags hold.
- TRAP, trap_ack=1: state <= RUN at the edge. A load_req in that same cycle is still ignored. The fault flags stay asserted until the next successful load or the next fault overwrites them.
- A successful load in RUN clears both fault flags.
- trap_ack in RUN: no effect.
- pc_write and pc_write_cond both asserted: treated as one load; load_cnt increments by 1.
- next_pc is purely combinational from sel/src_flat and is valid in every state.

Test Plan:
- Reset then idle: reset pulse mid-cycle -> pc=0, epc=0, load_cnt=0, in_trap=0 immediately; with no writes, pc stays 0 for 10 cycles.
- Normal select: src1=32'h0000_0040, sel=1, pc_write=1 -> next cycle pc=32'h40, load_cnt=1. Then pc_write_cond=1, cond=0, sel=2 -> pc stays 32'h40. Then cond=1 with src2=32'h80 -> pc=32'h80, load_cnt=2.
- Misalignment trap: pc=32'h80, sel=3, src3=32'h0000_0102, pc_write=1 -> pc=32'hFF, epc=32'h80, in_trap=1, fault_align=1, fault_sel=0, load_cnt unchanged. pc_write held 3 cycles -> pc stays 32'hFF. trap_ack=1 -> in_trap=0 next cycle. Load src0=32'h4 -> pc=32'h4, fault_align=0.
- Out-of-range select: NUM_SRC=6, sel=7, pc_write=1 -> next_pc=0, pc=32'hFF, fault_sel=1, fault_align=0, epc=previous pc.
- Counter wrap and parameter sweep: force 65536 successful loads -> load_cnt returns to 0. Re-elaborate with DATA_W=16, NUM_SRC=4, SEL_W=2, ALIGN_CHECK=0 -> target 16'h0003 loads without fault; sel=3 is valid.
- Reset during TRAP: assert reset while in_trap=1 -> pc=RESET_PC, state RUN, flags and epc cleared, with no trap_ack needed.
